// File: rtl/branch_sequencer.sv
// Multi-cycle branch resolution controller between ID and the shared Comparator.
// Define BRANCH_STATS_EN to add saturating taken/not-taken counters.
module branch_sequencer #(
  parameter int unsigned STATS_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               br_valid,
  output logic               br_ready,
  input  logic [3:0]         br_ctrl,
  input  logic               br_uncond,
  input  logic [31:0]        br_pc,
  input  logic [15:0]        br_offset,
  input  logic [31:0]        opA,
  input  logic [31:0]        opB,
  input  logic               opnd_ready,
  output logic [31:0]        cmp_A,
  output logic [31:0]        cmp_B,
  output logic [3:0]         cmp_ctrl,
  input  logic               cmp_action,
  output logic               resolve_valid,
  output logic               resolve_taken,
  output logic               redirect_valid,
  input  logic               redirect_ready,
  output logic [31:0]        redirect_pc
`ifdef BRANCH_STATS_EN
  ,
  output logic [STATS_W-1:0] taken_cnt,
  output logic [STATS_W-1:0] nottaken_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_OPND = 2'd1,
    RESOLVE   = 2'd2,
    REDIRECT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cmp_a_q, cmp_a_d;
  logic [31:0] cmp_b_q, cmp_b_d;
  logic [3:0]  cmp_ctrl_q, cmp_ctrl_d;
  logic        uncond_q, uncond_d;
  logic [31:0] target_q, target_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        taken;
  logic [31:0] br_target;

  assign br_target = br_pc + 32'd4 + {{14{br_offset[15]}}, br_offset, 2'b00};

  always_comb begin
    state_d       = state_q;
    cmp_a_d       = cmp_a_q;
    cmp_b_d       = cmp_b_q;
    cmp_ctrl_d    = cmp_ctrl_q;
    uncond_d      = uncond_q;
    target_d      = target_q;
    redirect_pc_d = redirect_pc_q;

    taken          = uncond_q | cmp_action;
    br_ready       = (state_q == IDLE) & ~flush;
    resolve_valid  = (state_q == RESOLVE) & ~flush;
    resolve_taken  = resolve_valid & taken;
    redirect_valid = (state_q == REDIRECT);

    // Flush wins over every state transition and suppresses all captures.
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (br_valid) begin
            cmp_ctrl_d = br_ctrl;
            uncond_d   = br_uncond;
            target_d   = br_target;
            if (opnd_ready) begin
              cmp_a_d = opA;
              cmp_b_d = opB;
              state_d = RESOLVE;
            end else begin
              state_d = WAIT_OPND;
            end
          end
        end
        WAIT_OPND: begin
          if (opnd_ready) begin
            cmp_a_d = opA;
            cmp_b_d = opB;
            state_d = RESOLVE;
          end
        end
        RESOLVE: begin
          if (taken) begin
            redirect_pc_d = target_q;
            state_d       = REDIRECT;
          end else begin
            state_d = IDLE;
          end
        end
        REDIRECT: begin
          if (redirect_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cmp_a_q       <= '0;
      cmp_b_q       <= '0;
      cmp_ctrl_q    <= '0;
      uncond_q      <= 1'b0;
      target_q      <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      cmp_a_q       <= cmp_a_d;
      cmp_b_q       <= cmp_b_d;
      cmp_ctrl_q    <= cmp_ctrl_d;
      uncond_q      <= uncond_d;
      target_q      <= target_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign cmp_A       = cmp_a_q;
  assign cmp_B       = cmp_b_q;
  assign cmp_ctrl    = cmp_ctrl_q;
  assign redirect_pc = redirect_pc_q;

`ifdef BRANCH_STATS_EN
  logic [STATS_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [STATS_W-1:0] nottaken_cnt_q, nottaken_cnt_d;

  // resolve_valid already excludes flushed RESOLVE cycles.
  always_comb begin
    taken_cnt_d    = taken_cnt_q;
    nottaken_cnt_d = nottaken_cnt_q;
    if (resolve_valid) begin
      if (taken) begin
        if (taken_cnt_q != '1) taken_cnt_d = taken_cnt_q + 1'b1;
      end else begin
        if (nottaken_cnt_q != '1) nottaken_cnt_d = nottaken_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      taken_cnt_q    <= '0;
      nottaken_cnt_q <= '0;
    end else begin
      taken_cnt_q    <= taken_cnt_d;
      nottaken_cnt_q <= nottaken_cnt_d;
    end
  end

  assign taken_cnt    = taken_cnt_q;
  assign nottaken_cnt = nottaken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: directed vector table, corner sequences and random traffic vs. a cycle model.
module tb_branch_sequencer;
  localparam int unsigned STATS_W = 32;

  logic        clk = 1'b0;
  logic        reset, flush, br_valid, br_ready, br_uncond, opnd_ready;
  logic [3:0]  br_ctrl, cmp_ctrl;
  logic [31:0] br_pc, opA, opB, cmp_A, cmp_B, redirect_pc;
  logic [15:0] br_offset;
  logic        cmp_action, resolve_valid, resolve_taken, redirect_valid, redirect_ready;
`ifdef BRANCH_STATS_EN
  logic [STATS_W-1:0] taken_cnt, nottaken_cnt;
`endif

  always #5 clk = ~clk;

  branch_sequencer #(.STATS_W(STATS_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .br_valid(br_valid), .br_ready(br_ready), .br_ctrl(br_ctrl), .br_uncond(br_uncond),
    .br_pc(br_pc), .br_offset(br_offset), .opA(opA), .opB(opB), .opnd_ready(opnd_ready),
    .cmp_A(cmp_A), .cmp_B(cmp_B), .cmp_ctrl(cmp_ctrl), .cmp_action(cmp_action),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready), .redirect_pc(redirect_pc)
`ifdef BRANCH_STATS_EN
    , .taken_cnt(taken_cnt), .nottaken_cnt(nottaken_cnt)
`endif
  );

  // Comparator codes used on this bench: 0 eq, 1 ne, 2 ltz, 3 gez, 4 gtz, 5 lez, others never match.
  localparam logic [3:0] C_EQ = 4'd0, C_NE = 4'd1, C_LTZ = 4'd2;

  function automatic logic cmp_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd0:    return a == b;
      4'd1:    return a != b;
      4'd2:    return $signed(a) < 0;
      4'd3:    return $signed(a) >= 0;
      4'd4:    return $signed(a) > 0;
      4'd5:    return $signed(a) <= 0;
      default: return 1'b0;
    endcase
  endfunction

  assign cmp_action = cmp_fn(cmp_ctrl, cmp_A, cmp_B);

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 waiting for operands, 2 resolving, 3 redirect pending.
  int          m_phase = 0;
  bit          m_known = 0;
  logic [31:0] m_a, m_b, m_tgt, m_rpc;
  logic [3:0]  m_ctrl;
  logic        m_unc;
  int unsigned m_tk, m_nt;

  task automatic check_and_step();
    logic exp_taken;
    exp_taken = m_unc | cmp_fn(m_ctrl, m_a, m_b);
    if (!reset && m_known) begin
      chk("br_ready", br_ready, (m_phase == 0) && !flush);
      chk("resolve_valid", resolve_valid, (m_phase == 2) && !flush);
      if (m_phase == 2 && !flush) chk("resolve_taken", resolve_taken, exp_taken);
      chk("redirect_valid", redirect_valid, m_phase == 3);
      chk("redirect_pc", redirect_pc, m_rpc);
      chk("cmp_A", cmp_A, m_a);
      chk("cmp_B", cmp_B, m_b);
      chk("cmp_ctrl", cmp_ctrl, m_ctrl);
`ifdef BRANCH_STATS_EN
      chk("taken_cnt", taken_cnt, m_tk);
      chk("nottaken_cnt", nottaken_cnt, m_nt);
`endif
    end
    if (reset) begin
      m_phase = 0; m_a = '0; m_b = '0; m_ctrl = '0; m_rpc = '0; m_unc = 0; m_tgt = '0;
      m_tk = 0; m_nt = 0; m_known = 1;
    end else if (flush) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (br_valid) begin
        m_ctrl = br_ctrl;
        m_unc  = br_uncond;
        m_tgt  = br_pc + 32'(4 + 4 * int'($signed(br_offset)));
        if (opnd_ready) begin m_a = opA; m_b = opB; m_phase = 2; end
        else m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (opnd_ready) begin m_a = opA; m_b = opB; m_phase = 2; end
    end else if (m_phase == 2) begin
      if (exp_taken) begin
        m_rpc = m_tgt; m_phase = 3;
        if (m_tk != 32'hFFFF_FFFF) m_tk++;
      end else begin
        m_phase = 0;
        if (m_nt != 32'hFFFF_FFFF) m_nt++;
      end
    end else begin
      if (redirect_ready) m_phase = 0;
    end
  endtask

  task automatic set_in(input logic rst, input logic fl, input logic bv, input logic [3:0] c,
                        input logic unc, input logic [31:0] pc, input logic [15:0] off,
                        input logic [31:0] a, input logic [31:0] b, input logic ordy, input logic rrdy);
    reset = rst; flush = fl; br_valid = bv; br_ctrl = c; br_uncond = unc; br_pc = pc;
    br_offset = off; opA = a; opB = b; opnd_ready = ordy; redirect_ready = rrdy;
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic rst, input logic fl, input logic bv, input logic [3:0] c,
                     input logic unc, input logic [31:0] pc, input logic [15:0] off,
                     input logic [31:0] a, input logic [31:0] b, input logic ordy, input logic rrdy);
    set_in(rst, fl, bv, c, unc, pc, off, a, b, ordy, rrdy);
    @(negedge clk);
    check_and_step();
    finish_cycle();
  endtask

  task automatic idle(input logic fl, input logic [31:0] a, input logic ordy, input logic rrdy);
    cyc(0, fl, 0, C_EQ, 0, 32'h0, 16'h0, a, 32'h0, ordy, rrdy);
  endtask

  typedef struct {
    logic fl, bv; logic [3:0] c; logic unc; logic [31:0] pc; logic [15:0] off;
    logic [31:0] a, b; logic ordy, rrdy;
    logic e_rdy, e_rv, e_rt, e_redv; logic [31:0] e_rpc;
  } vec_t;

  vec_t tbl[7];

  initial begin
    // beq taken then bne not taken, one row per cycle.
    tbl[0] = '{0, 1, C_EQ, 0, 32'h0040_0000, 16'h0003, 5, 5, 1, 1, 1, 0, 0, 0, 32'h0};
    tbl[1] = '{0, 0, C_EQ, 0, 32'h0, 16'h0, 0, 0, 1, 1, 0, 1, 1, 0, 32'h0};
    tbl[2] = '{0, 0, C_EQ, 0, 32'h0, 16'h0, 0, 0, 1, 1, 0, 0, 0, 1, 32'h0040_0010};
    tbl[3] = '{0, 0, C_EQ, 0, 32'h0, 16'h0, 0, 0, 1, 1, 1, 0, 0, 0, 32'h0040_0010};
    tbl[4] = '{0, 1, C_NE, 0, 32'h0040_0100, 16'h0005, 7, 7, 1, 1, 1, 0, 0, 0, 32'h0040_0010};
    tbl[5] = '{0, 0, C_EQ, 0, 32'h0, 16'h0, 0, 0, 1, 1, 0, 1, 0, 0, 32'h0040_0010};
    tbl[6] = '{0, 0, C_EQ, 0, 32'h0, 16'h0, 0, 0, 1, 1, 1, 0, 0, 0, 32'h0040_0010};

    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      set_in(0, tbl[i].fl, tbl[i].bv, tbl[i].c, tbl[i].unc, tbl[i].pc, tbl[i].off,
             tbl[i].a, tbl[i].b, tbl[i].ordy, tbl[i].rrdy);
      @(negedge clk);
      chk($sformatf("vec%0d_br_ready", i), br_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d_resolve_valid", i), resolve_valid, tbl[i].e_rv);
      chk($sformatf("vec%0d_resolve_taken", i), resolve_taken, tbl[i].e_rt);
      chk($sformatf("vec%0d_redirect_valid", i), redirect_valid, tbl[i].e_redv);
      chk($sformatf("vec%0d_redirect_pc", i), redirect_pc, tbl[i].e_rpc);
      check_and_step();
      finish_cycle();
    end

    // Operand stall: bltz waits three cycles, negative offset targets the branch itself, then backpressure.
    cyc(0, 0, 1, C_LTZ, 0, 32'h0040_2000, 16'hFFFF, 32'h1111, 0, 0, 0);
    for (int unsigned k = 0; k < 3; k++) idle(0, 32'h2222 + k, 0, 0);
    idle(0, 32'hFFFF_FFFF, 1, 0);
    idle(0, 0, 0, 0);
    for (int unsigned k = 0; k < 4; k++) begin
      set_in(0, 0, 1, C_EQ, 0, 0, 0, 0, 0, 1, 0);
      @(negedge clk);
      chk("bp_redirect_valid", redirect_valid, 1'b1);
      chk("bp_redirect_pc", redirect_pc, 32'h0040_2000);
      chk("bp_br_ready", br_ready, 1'b0);
      check_and_step();
      finish_cycle();
    end
    idle(0, 0, 0, 1);
    idle(0, 0, 0, 1);

    // Flush while waiting for operands.
    cyc(0, 0, 1, C_EQ, 1, 32'h0050_0000, 16'h0010, 0, 0, 0, 1);
    idle(1, 32'h3333, 1, 1);
    idle(0, 0, 0, 1);
    idle(0, 0, 0, 1);
    // Flush during RESOLVE discards the outcome.
    cyc(0, 0, 1, C_EQ, 1, 32'h0050_0100, 16'h0010, 9, 9, 1, 1);
    idle(1, 0, 0, 1);
    idle(0, 0, 0, 1);
    // Flush in REDIRECT, with and without redirect_ready.
    cyc(0, 0, 1, C_EQ, 1, 32'h0050_0200, 16'h0020, 1, 2, 1, 0);
    idle(0, 0, 0, 0);
    idle(0, 0, 0, 0);
    idle(1, 0, 0, 0);
    idle(0, 0, 0, 0);
    cyc(0, 0, 1, C_EQ, 1, 32'h0050_0300, 16'h0020, 1, 2, 1, 0);
    idle(0, 0, 0, 0);
    idle(1, 0, 0, 1);
    idle(0, 0, 0, 0);
    // Flush with a branch offered in IDLE: not accepted.
    cyc(0, 1, 1, C_EQ, 1, 32'h0050_0400, 16'h0001, 4, 4, 1, 1);
    idle(0, 0, 0, 1);

    // Reset in the middle of REDIRECT.
    cyc(0, 0, 1, C_EQ, 1, 32'h0060_0000, 16'h0008, 6, 6, 1, 0);
    idle(0, 0, 0, 0);
    idle(0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_redirect_valid", redirect_valid, 1'b0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_cmp_A", cmp_A, 32'h0);
    chk("rst_br_ready", br_ready, 1'b1);
    check_and_step();
    finish_cycle();

    // Two taken and one not-taken branch after reset.
    cyc(0, 0, 1, C_EQ, 1, 32'h0070_0000, 16'h0001, 1, 2, 1, 1);
    idle(0, 0, 0, 1); idle(0, 0, 0, 1);
    cyc(0, 0, 1, C_EQ, 0, 32'h0070_0100, 16'h0001, 3, 3, 1, 1);
    idle(0, 0, 0, 1); idle(0, 0, 0, 1);
    cyc(0, 0, 1, 4'd9, 0, 32'h0070_0200, 16'h0001, 3, 3, 1, 1);
    idle(0, 0, 0, 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
`ifdef BRANCH_STATS_EN
    chk("stats_taken", taken_cnt, 32'd2);
    chk("stats_nottaken", nottaken_cnt, 32'd1);
`endif
    chk("stats_br_ready", br_ready, 1'b1);
    check_and_step();
    finish_cycle();

    // Random traffic against the model.
    for (int unsigned n = 0; n < 3000; n++) begin
      cyc(($urandom % 250) == 0, ($urandom % 25) == 0, $urandom % 2, 4'($urandom % 8),
          ($urandom % 4) == 0, $urandom, 16'($urandom), 32'($urandom % 3) - 32'd1,
          32'($urandom % 3) - 32'd1, ($urandom % 3) != 0, $urandom % 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
